pipe_mem_arbiter: RTL and testbench

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

---
 rtl/pipe_mem_arbiter.sv | 109 ++++++++++
 tb/tb_pipe_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// Data-memory arbiter between the MW pipeline stage and an external loader/debug port.
// The core has priority, with starvation-forced ext grants and locked ext bursts.
module pipe_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  input  logic        ext_req_i,
  input  logic        ext_lock_i,
  input  logic        ext_we_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_wdata_i,
  output logic        ext_gnt_o,
  output logic        ext_rvalid_o,
  output logic [31:0] ext_rdata_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        dbg_state,
  output logic [3:0]  dbg_starve_cnt,
  output logic [3:0]  dbg_beat_cnt
);

  // Ext handshake: ext holds req/addr/wdata stable until a cycle with ext_gnt_o = 1;
  // every grant cycle is exactly one transfer, and reads return one cycle later on ext_rvalid_o.

  typedef enum logic {ARB_CORE = 1'b0, ARB_EXT = 1'b1} arb_state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
  localparam logic       BURST_EN   = (BURST_MAX > 1);

  arb_state_t state, state_next;
  logic [3:0] starve_cnt, beat_cnt;
  logic       starve_hit, gnt, stall, leave_ext;

  assign starve_hit = (starve_cnt == STARVE_LIM);
  assign leave_ext  = ~ext_req_i | ~ext_lock_i | (gnt & (beat_cnt + 4'd1 == BURST_LIM));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= ARB_CORE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_CORE: if (gnt & ext_lock_i & BURST_EN) state_next = ARB_EXT;
      ARB_EXT:  if (leave_ext) state_next = ARB_CORE;
      default:  state_next = ARB_CORE;
    endcase
  end

  always_comb begin
    gnt   = 1'b0;
    stall = 1'b0;
    if (rst_n_i) begin
      if (state == ARB_EXT) begin
        gnt   = ext_req_i;
        stall = core_req_i;
      end else begin
        gnt   = ext_req_i & (~core_req_i | starve_hit);
        stall = core_req_i & gnt;
      end
    end
  end

  assign ext_gnt_o    = gnt;
  assign core_stall_o = stall;
  assign mem_addr_o   = gnt ? ext_addr_i  : core_addr_i;
  assign mem_wdata_o  = gnt ? ext_wdata_i : core_wdata_i;
  assign mem_we_o     = rst_n_i & (gnt ? ext_we_i : (core_req_i & core_we_i & ~stall));
  assign core_rdata_o = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_cnt   <= 4'd0;
      beat_cnt     <= 4'd0;
      ext_rvalid_o <= 1'b0;
      ext_rdata_o  <= 32'h0;
    end else begin
      ext_rvalid_o <= gnt & ~ext_we_i;
      if (gnt & ~ext_we_i) ext_rdata_o <= mem_rdata_i;
      if (state == ARB_CORE) begin
        if (gnt)                           starve_cnt <= 4'd0;
        else if (ext_req_i & ~starve_hit)  starve_cnt <= starve_cnt + 4'd1;
        beat_cnt <= (state_next == ARB_EXT) ? 4'd1 : 4'd0;
      end else begin
        // Inside a burst every cycle either grants ext or ends the burst; both clear it.
        starve_cnt <= 4'd0;
        if (leave_ext) beat_cnt <= 4'd0;
        else if (gnt)  beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;
  assign dbg_beat_cnt   = beat_cnt;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with a small data memory model and an
// ext read-data scoreboard.
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ext_req, ext_lock, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dbg_state;
  logic [3:0]  dbg_starve_cnt, dbg_beat_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  pipe_mem_arbiter #(.STARVE_MAX(4), .BURST_MAX(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .ext_req_i(ext_req), .ext_lock_i(ext_lock), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt), .dbg_beat_cnt(dbg_beat_cnt)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read-data scoreboard: each granted ext read pushes its expected data.
  always @(negedge clk) begin
    if (ext_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rvalid_unexpected observed=%h expected=none", ext_rdata);
      end else begin
        check("rvalid_data", ext_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h1234;
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h5;
    step();
    #3;
    check("rst_gnt", {31'd0, ext_gnt}, 32'd0);
    check("rst_stall", {31'd0, core_stall}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    step();
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    check("rst_starve", {28'd0, dbg_starve_cnt}, 32'd0);
    check("rst_beat", {28'd0, dbg_beat_cnt}, 32'd0);
    check("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rst_rdata", ext_rdata, 32'h0);
    rst_n = 1'b1;
    ext_req = 1'b0; ext_lock = 1'b0; core_req = 1'b0; core_we = 1'b0;
    #3;
    check("idle_we", {31'd0, mem_we}, 32'd0);
    check("idle_addr", mem_addr, 32'h10);
    step();

    // Core store then load.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
    #3;
    check("core_st_we", {31'd0, mem_we}, 32'd1);
    check("core_st_addr", mem_addr, 32'h10);
    check("core_st_stall", {31'd0, core_stall}, 32'd0);
    step();
    core_we = 1'b0;
    #3;
    check("core_ld_data", core_rdata, 32'hDEADBEEF);
    check("core_ld_stall", {31'd0, core_stall}, 32'd0);
    check("core_ld_we", {31'd0, mem_we}, 32'd0);
    step();

    // Ext read in an idle slot.
    core_req = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #3;
    check("ext_rd_gnt", {31'd0, ext_gnt}, 32'd1);
    check("ext_rd_addr", mem_addr, 32'h10);
    exp_q.push_back(32'hDEADBEEF);
    step();
    ext_req = 1'b0;
    check("ext_rd_rvalid", {31'd0, ext_rvalid}, 32'd1);
    check("ext_rd_rdata", ext_rdata, 32'hDEADBEEF);
    step();
    check("ext_rd_rvalid_off", {31'd0, ext_rvalid}, 32'd0);
    check("ext_rd_hold", ext_rdata, 32'hDEADBEEF);

    // Starvation: core and ext both requesting.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("starve_cnt", {28'd0, dbg_starve_cnt}, 32'(i));
      check("starve_deny", {31'd0, ext_gnt}, 32'd0);
      check("starve_core_run", {31'd0, core_stall}, 32'd0);
      step();
    end
    #3;
    check("starve_sat", {28'd0, dbg_starve_cnt}, 32'd4);
    check("starve_force_gnt", {31'd0, ext_gnt}, 32'd1);
    check("starve_force_stall", {31'd0, core_stall}, 32'd1);
    check("starve_force_addr", mem_addr, 32'h40);
    check("starve_force_we", {31'd0, mem_we}, 32'd1);
    step();
    ext_req = 1'b0;
    #3;
    check("starve_clear", {28'd0, dbg_starve_cnt}, 32'd0);
    check("starve_core_go", {31'd0, core_stall}, 32'd0);
    check("starve_core_data", core_rdata, 32'hDEADBEEF);
    step();

    // Locked burst of writes; core joins from beat 2.
    core_req = 1'b0; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'hBAD;
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      core_req = (k > 1);
      ext_addr = 32'h20 + 32'(4 * (k - 1));
      ext_wdata = 32'hA0 + 32'(k - 1);
      #3;
      check("burst_gnt", {31'd0, ext_gnt}, 32'd1);
      check("burst_stall", {31'd0, core_stall}, 32'(k > 1));
      check("burst_we", {31'd0, mem_we}, 32'd1);
      check("burst_addr", mem_addr, ext_addr);
      step();
      check("burst_state", {31'd0, dbg_state}, 32'(k < 4));
      check("burst_beat", {28'd0, dbg_beat_cnt}, (k < 4) ? 32'(k) : 32'd0);
    end
    ext_addr = 32'h30; ext_wdata = 32'hA4;
    #3;
    check("post_burst_core_gnt", {31'd0, core_stall}, 32'd0);
    check("post_burst_ext_deny", {31'd0, ext_gnt}, 32'd0);
    check("post_burst_core_addr", mem_addr, 32'h80);
    check("post_burst_core_we", {31'd0, mem_we}, 32'd1);
    step();
    check("post_burst_starve", {28'd0, dbg_starve_cnt}, 32'd1);
    core_req = 1'b0; ext_lock = 1'b0;
    #3;
    check("unlocked_gnt", {31'd0, ext_gnt}, 32'd1);
    step();
    check("unlocked_state", {31'd0, dbg_state}, 32'd0);
    ext_addr = 32'h34; ext_wdata = 32'hA5;
    step();
    ext_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h2C;
    #3;
    check("mem_beat3", core_rdata, 32'hA3);
    step();
    core_addr = 32'h34;
    #3;
    check("mem_beat5", core_rdata, 32'hA5);
    step();
    core_addr = 32'h80;
    #3;
    check("mem_core_st", core_rdata, 32'hBAD);
    step();

    // Lock dropped on the 2nd beat; core store stalled meanwhile.
    core_req = 1'b0; ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #3;
    check("drop_gnt1", {31'd0, ext_gnt}, 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    step();
    check("drop_state1", {31'd0, dbg_state}, 32'd1);
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h84; core_wdata = 32'h55;
    ext_addr = 32'h20; ext_lock = 1'b0;
    #3;
    check("drop_gnt2", {31'd0, ext_gnt}, 32'd1);
    check("drop_stall", {31'd0, core_stall}, 32'd1);
    check("drop_no_core_we", {31'd0, mem_we}, 32'd0);
    exp_q.push_back(32'hA0);
    step();
    check("drop_state2", {31'd0, dbg_state}, 32'd0);
    check("drop_beat", {28'd0, dbg_beat_cnt}, 32'd0);
    ext_req = 1'b0;
    #3;
    check("drop_core_we", {31'd0, mem_we}, 32'd1);
    check("drop_core_addr", mem_addr, 32'h84);
    step();

    // Reset during beat 2 of a locked write burst.
    core_req = 1'b0; ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1;
    ext_addr = 32'h90; ext_wdata = 32'h77;
    step();
    check("rstb_state", {31'd0, dbg_state}, 32'd1);
    ext_addr = 32'h94; ext_wdata = 32'h88; rst_n = 1'b0;
    #3;
    check("rstb_no_we", {31'd0, mem_we}, 32'd0);
    check("rstb_no_gnt", {31'd0, ext_gnt}, 32'd0);
    step();
    rst_n = 1'b1; ext_req = 1'b0; ext_lock = 1'b0;
    check("rstb_state_core", {31'd0, dbg_state}, 32'd0);
    check("rstb_beat", {28'd0, dbg_beat_cnt}, 32'd0);
    check("rstb_starve", {28'd0, dbg_starve_cnt}, 32'd0);
    check("rstb_rvalid", {31'd0, ext_rvalid}, 32'd0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h94;
    #3;
    check("rstb_mem_untouched", core_rdata, 32'h0);
    step();
    core_req = 1'b0;
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
